// File: rtl/detector_adc_sequencer_pkg.sv
// detector_adc_sequencer_pkg: shared state encoding and ADC frame constants for the LocTag detector path.
package detector_adc_sequencer_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, SHIFT, QUIET, DONE} seq_state_t;

    localparam int ADC_FRAME_BITS = 16;
    localparam int ADC_LEAD_ZEROS = 4;
    localparam int ADC_DATA_BITS  = ADC_FRAME_BITS - ADC_LEAD_ZEROS;

    // Defaults for a 16 MHz system clock: 2 MHz SCLK, 10 us detector settle.
    localparam int DEF_CLK_DIV       = 4;
    localparam int DEF_SETTLE_CYCLES = 160;
    localparam int DEF_BURST_LEN     = 8;
    localparam int DEF_QUIET_CYCLES  = 4;

    function automatic int count_width(input int a, input int b);
        return $clog2((a > b ? a : b) + 1);
    endfunction

endpackage

// File: rtl/detector_adc_sequencer_if.sv
// detector_adc_sequencer_if: ADC serial pins plus the sample stream handed to downstream consumers.
interface detector_adc_sequencer_if
    import detector_adc_sequencer_pkg::*;
#(
    parameter int DATA_BITS = ADC_DATA_BITS
);
    logic                 adc_cs_n;
    logic                 adc_sclk;
    logic                 adc_sdo;
    logic [DATA_BITS-1:0] sample_data;
    logic [7:0]           sample_index;
    logic                 sample_valid;

    modport master (
        output adc_cs_n, adc_sclk, sample_data, sample_index, sample_valid,
        input  adc_sdo
    );

    modport slave (
        input  adc_cs_n, adc_sclk, sample_data, sample_index, sample_valid,
        output adc_sdo
    );
endinterface

// File: rtl/detector_adc_sequencer_adc_serial_frame.sv
// adc_serial_frame: drives CS/SCLK for a single ADC frame and shifts SDO in, MSB first, on each SCLK rise.
module adc_serial_frame
    import detector_adc_sequencer_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int FRAME_BITS = ADC_FRAME_BITS,
    parameter int DATA_BITS  = ADC_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 sdo,
    output logic                 cs_n,
    output logic                 sclk,
    output logic                 last,
    output logic [DATA_BITS-1:0] data
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int RW = $clog2(FRAME_BITS + 1);

    logic [DW-1:0] div_cnt;
    logic [RW-1:0] rise_cnt;
    logic          tick;

    assign tick = div_cnt == DW'(CLK_DIV - 1);
    assign last = !cs_n && rise_cnt == RW'(FRAME_BITS);

    // Only the final DATA_BITS samples are kept; the leading frame bits fall off the top.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_n     <= 1'b1;
            sclk     <= 1'b1;
            div_cnt  <= '0;
            rise_cnt <= '0;
            data     <= '0;
        end else if (stop || last) begin
            cs_n <= 1'b1;
            sclk <= 1'b1;
        end else if (start) begin
            cs_n     <= 1'b0;
            sclk     <= 1'b1;
            div_cnt  <= '0;
            rise_cnt <= '0;
        end else if (!cs_n) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) sclk <= ~sclk;
            if (tick && !sclk) begin
                data     <= {data[DATA_BITS-2:0], sdo};
                rise_cnt <= rise_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/detector_adc_sequencer.sv
// detector_adc_sequencer: enables the LT5534, waits for settle, then runs a burst of serial ADC conversions.
module detector_adc_sequencer
    import detector_adc_sequencer_pkg::*;
#(
    parameter int CLK_DIV       = DEF_CLK_DIV,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int FRAME_BITS    = ADC_FRAME_BITS,
    parameter int DATA_BITS     = ADC_DATA_BITS,
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int QUIET_CYCLES  = DEF_QUIET_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic trig_async,
    input  logic trig_en,
    input  logic abort,
    output logic det_en,
    output logic busy,
    output logic done,
    detector_adc_sequencer_if.master bus
);
    localparam int CW = count_width(SETTLE_CYCLES, QUIET_CYCLES);

    seq_state_t           state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [7:0]           conv, conv_n;
    logic [1:0]           trig_sync;
    logic                 trig_prev;
    logic                 trig_rise, go, more;
    logic                 frame_start, frame_last, frame_cs_n, frame_sclk;
    logic                 valid_n;
    logic [DATA_BITS-1:0] frame_data;
    logic [DATA_BITS-1:0] sample_data;
    logic [7:0]           sample_index;
    logic                 sample_valid;

    assign trig_rise = trig_sync[1] & ~trig_prev;
    assign go        = start | (trig_rise & trig_en);
    assign more      = ({1'b0, conv} + 9'd1) < 9'(BURST_LEN);

    assign bus.adc_cs_n     = frame_cs_n;
    assign bus.adc_sclk     = frame_sclk;
    assign bus.sample_data  = sample_data;
    assign bus.sample_index = sample_index;
    assign bus.sample_valid = sample_valid;

    adc_serial_frame #(
        .CLK_DIV    (CLK_DIV),
        .FRAME_BITS (FRAME_BITS),
        .DATA_BITS  (DATA_BITS)
    ) u_frame (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (frame_start),
        .stop    (abort),
        .sdo     (bus.adc_sdo),
        .cs_n    (frame_cs_n),
        .sclk    (frame_sclk),
        .last    (frame_last),
        .data    (frame_data)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        conv_n      = conv;
        frame_start = 1'b0;
        valid_n     = 1'b0;
        case (state)
            IDLE: if (go && !abort) begin
                state_n = SETTLE;
                cnt_n   = CW'(SETTLE_CYCLES - 1);
                conv_n  = '0;
            end
            SETTLE: if (abort) state_n = IDLE;
            else if (cnt == '0) begin
                state_n     = SHIFT;
                frame_start = 1'b1;
            end else cnt_n = cnt - 1'b1;
            SHIFT: if (abort) state_n = IDLE;
            else if (frame_last) begin
                state_n = QUIET;
                cnt_n   = CW'(QUIET_CYCLES - 1);
                valid_n = 1'b1;
            end
            QUIET: if (abort) state_n = IDLE;
            else if (cnt != '0) cnt_n = cnt - 1'b1;
            else if (more) begin
                state_n     = SHIFT;
                conv_n      = conv + 1'b1;
                frame_start = 1'b1;
            end else state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they stay registered yet line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            conv         <= '0;
            det_en       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_data  <= '0;
            sample_index <= '0;
            sample_valid <= 1'b0;
            trig_sync    <= '0;
            trig_prev    <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            conv         <= conv_n;
            det_en       <= state_n inside {SETTLE, SHIFT, QUIET};
            busy         <= state_n != IDLE;
            done         <= state_n == DONE;
            sample_valid <= valid_n;
            if (valid_n) begin
                sample_data  <= frame_data;
                sample_index <= conv;
            end
            trig_sync <= {trig_sync[0], trig_async};
            trig_prev <= trig_sync[1];
        end
    end

endmodule

// File: tb/tb_detector_adc_sequencer.sv
// tb_detector_adc_sequencer: directed/randomised bench with a behavioural ADC and a cycle-timing reference.
module tb_detector_adc_sequencer;
    logic clk = 1'b0;
    bit   clk_run = 1'b1;
    logic reset_n, start_a, start_b, trig_async, trig_en, abort;
    logic det_en_a, busy_a, done_a, det_en_b, busy_b, done_b;
    int   tests = 0;
    int   failed = 0;

    detector_adc_sequencer_if bus_a ();
    detector_adc_sequencer_if bus_b ();

    detector_adc_sequencer dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .trig_async(trig_async),
        .trig_en(trig_en), .abort(abort), .det_en(det_en_a), .busy(busy_a),
        .done(done_a), .bus(bus_a)
    );

    detector_adc_sequencer #(.CLK_DIV(2), .BURST_LEN(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .trig_async(trig_async),
        .trig_en(1'b0), .abort(abort), .det_en(det_en_b), .busy(busy_b),
        .done(done_b), .bus(bus_b)
    );

    always #5 if (clk_run) clk = ~clk;

    // ADC models: a new word per CS fall, next bit presented on every SCLK fall.
    logic [15:0] word_a;
    logic [15:0] fixed_a = 16'h0ABC;
    logic [15:0] word_b = 16'hFFFF;
    bit          rand_a = 1'b0;
    logic [15:0] served[$];
    int          bit_a, bit_b;

    always @(negedge bus_a.adc_cs_n) begin
        word_a = rand_a ? 16'($urandom) : fixed_a;
        served.push_back(word_a);
        bit_a = 15;
    end
    always @(negedge bus_a.adc_sclk) if (!bus_a.adc_cs_n && bit_a >= 0) begin
        bus_a.adc_sdo = word_a[bit_a];
        bit_a--;
    end
    always @(negedge bus_b.adc_cs_n) bit_b = 15;
    always @(negedge bus_b.adc_sclk) if (!bus_b.adc_cs_n && bit_b >= 0) begin
        bus_b.adc_sdo = word_b[bit_b];
        bit_b--;
    end

    bit sel = 1'b0;
    wire        m_busy  = sel ? busy_b : busy_a;
    wire        m_det   = sel ? det_en_b : det_en_a;
    wire        m_done  = sel ? done_b : done_a;
    wire        m_cs    = sel ? bus_b.adc_cs_n : bus_a.adc_cs_n;
    wire        m_sclk  = sel ? bus_b.adc_sclk : bus_a.adc_sclk;
    wire        m_valid = sel ? bus_b.sample_valid : bus_a.sample_valid;
    wire [11:0] m_data  = sel ? bus_b.sample_data : bus_a.sample_data;
    wire [7:0]  m_idx   = sel ? bus_b.sample_index : bus_a.sample_index;

    int         cyc, first_det, first_cs, first_busy, busy_end;
    int         abort_at = -10;
    bit         noise = 1'b0;
    int         v_cyc[$], v_idx[$], d_cyc[$];
    logic [11:0] v_dat[$];
    logic [2:0] after_abort;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Steps the clock, logging events relative to cycle 0 (the cycle before the first tick).
    task automatic run(input int budget);
        bit seen = 1'b0;
        cyc = 0; first_det = -1; first_cs = -1; first_busy = -1; busy_end = -1;
        v_cyc.delete(); v_idx.delete(); v_dat.delete(); d_cyc.delete(); served.delete();
        while (cyc < budget) begin
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0; abort = 1'b0;
            cyc++;
            if (m_det && first_det < 0) first_det = cyc;
            if (!m_cs && first_cs < 0) first_cs = cyc;
            if (m_busy && first_busy < 0) first_busy = cyc;
            if (m_valid) begin
                v_cyc.push_back(cyc); v_dat.push_back(m_data); v_idx.push_back(int'(m_idx));
            end
            if (m_done) d_cyc.push_back(cyc);
            if (cyc == abort_at + 1) after_abort = {m_cs, m_sclk, m_det};
            if (cyc == abort_at) abort = 1'b1;
            if (noise && m_busy && cyc % 37 == 5) start_a = 1'b1;
            if (m_busy) seen = 1'b1;
            else if (seen) begin
                busy_end = cyc;
                break;
            end
        end
    endtask

    task automatic check_burst(input string tag);
        logic [15:0] w;
        check({tag, "_strobes"}, v_cyc.size(), 8);
        check({tag, "_done"}, d_cyc.size(), 1);
        for (int i = 0; i < 8; i++) begin
            w = (i < served.size()) ? served[i] : 16'hxxxx;
            check({tag, "_data"}, (i < v_dat.size()) ? 32'(v_dat[i]) : 32'hDEAD, 32'(w[11:0]));
            check({tag, "_index"}, (i < v_idx.size()) ? v_idx[i] : -1, i);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_det_en"}, det_en_a, 0);
        check({tag, "_cs_n"}, bus_a.adc_cs_n, 1);
        check({tag, "_sclk"}, bus_a.adc_sclk, 1);
        check({tag, "_data"}, bus_a.sample_data, 0);
        check({tag, "_index"}, bus_a.sample_index, 0);
        check({tag, "_valid"}, bus_a.sample_valid, 0);
        check({tag, "_busy"}, busy_a, 0);
        check({tag, "_done"}, done_a, 0);
    endtask

    initial begin
        reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        trig_async = 1'b0; trig_en = 1'b0; abort = 1'b0;
        bus_a.adc_sdo = 1'b0; bus_b.adc_sdo = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("rst");

        // Default burst with a fixed ADC word: absolute timing of every event.
        start_a = 1'b1;
        run(1500);
        check("t1_det_rise", first_det, 1);
        check("t1_cs_fall", first_cs, 161);
        check("t1_strobes", v_cyc.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("t1_strobe_cycle", (i < v_cyc.size()) ? v_cyc[i] : -1, 290 + 133 * i);
            check("t1_data", (i < v_dat.size()) ? 32'(v_dat[i]) : 32'hDEAD, 12'hABC);
            check("t1_index", (i < v_idx.size()) ? v_idx[i] : -1, i);
        end
        check("t1_done_count", d_cyc.size(), 1);
        check("t1_done_cycle", (d_cyc.size() > 0) ? d_cyc[0] : -1, 1225);
        check("t1_busy_end", busy_end, 1226);
        check("t1_det_after", det_en_a, 0);

        // Trigger-started burst, random words, trig held high and start pulses while busy.
        rand_a = 1'b1; trig_en = 1'b1; noise = 1'b1;
        @(posedge clk); #($urandom_range(2, 8));
        trig_async = 1'b1;
        run(1500);
        check("t2_latency", (first_busy >= 3 && first_busy <= 4), 1);
        check_burst("t2");
        noise = 1'b0;
        run(60);
        check("t2_no_retrigger", first_busy, -1);

        // Trigger rise with trig_en low must not start a run.
        trig_async = 1'b0;
        run(10);
        trig_en = 1'b0;
        trig_async = 1'b1;
        run(60);
        check("t3_trig_disabled", first_busy, -1);
        trig_async = 1'b0;

        // Abort somewhere inside conversion 3 (its frame spans cycles 560..688).
        abort_at = $urandom_range(561, 688);
        start_a = 1'b1;
        run(1500);
        check("t4_strobes", v_cyc.size(), 3);
        for (int i = 0; i < 3; i++) check("t4_index", (i < v_idx.size()) ? v_idx[i] : -1, i);
        check("t4_no_done", d_cyc.size(), 0);
        check("t4_pins_after", after_abort, 3'b110);
        check("t4_busy_end", busy_end, abort_at + 1);
        abort_at = -10;

        start_a = 1'b1;
        run(1500);
        check("t5_cs_fall", first_cs, 161);
        check_burst("t5");

        // Single-conversion instance at CLK_DIV=2 with an all-ones word.
        sel = 1'b1;
        start_b = 1'b1;
        run(500);
        check("t6_cs_fall", first_cs, 161);
        check("t6_strobes", v_cyc.size(), 1);
        check("t6_strobe_cycle", (v_cyc.size() > 0) ? v_cyc[0] : -1, 226);
        check("t6_data", (v_dat.size() > 0) ? 32'(v_dat[0]) : 32'hDEAD, 12'hFFF);
        check("t6_index", (v_idx.size() > 0) ? v_idx[0] : -1, 0);
        check("t6_done_cycle", (d_cyc.size() > 0) ? d_cyc[0] : -1, 230);
        check("t6_busy_end", busy_end, 231);
        sel = 1'b0;

        // Asynchronous reset in the middle of a frame with the clock stopped.
        start_a = 1'b1;
        run(200);
        check("t7_in_shift", bus_a.adc_cs_n, 0);
        clk_run = 1'b0;
        #3 reset_n = 1'b0;
        #1 check_reset_values("t7_async");
        #20 clk_run = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        run(300);
        check("t7_idle_busy", first_busy, -1);
        check("t7_idle_valid", v_cyc.size(), 0);
        check("t7_idle_done", d_cyc.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
